// File: rtl/lvda_int_sched_pkg.sv
// Shared types and helpers for the LVDA interrupt scheduler.
// The state enum, default sizing and the lowest-set-bit priority encode.
package lvda_int_pkg;

    localparam int NUM_INT_DEF = 12;
    localparam int IDX_W_DEF   = 4;
    localparam int HOLDOFF_DEF = 3;
    localparam int HOLD_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        HOLD
    } sched_state_t;

    // Index 0 is the highest priority, so scan downward and keep the last hit.
    function automatic int lowest_set(input logic [31:0] vec, input int width);
        lowest_set = 0;
        for (int i = width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set = i;
            end
        end
    endfunction

endpackage

// File: rtl/lvda_int_sched_if.sv
// Register-decode and computer-handshake bundle for the interrupt scheduler.
// The master side drives strobes and acknowledges; the scheduler is the slave.
interface lvda_int_sched_if #(
    parameter int NUM_INT = 12,
    parameter int IDX_W   = 4
);
    logic               V1;
    logic [NUM_INT-1:0] INT_RAW;
    logic               ICR_WR;
    logic               ICR_SET;
    logic [NUM_INT-1:0] ICR_DATA;
    logic               PEND_CLR;
    logic [NUM_INT-1:0] PEND_CLR_DATA;
    logic               INT_ACK;
    logic               INT_DONE;
    logic               INT_REQ;
    logic [IDX_W-1:0]   INT_VEC;
    logic [NUM_INT-1:0] ICR_Q;
    logic [NUM_INT-1:0] PEND_Q;
    logic               BUSY;
    logic               ACK_ERR;

    modport master (
        output V1, INT_RAW, ICR_WR, ICR_SET, ICR_DATA, PEND_CLR, PEND_CLR_DATA,
               INT_ACK, INT_DONE,
        input  INT_REQ, INT_VEC, ICR_Q, PEND_Q, BUSY, ACK_ERR
    );

    modport slave (
        input  V1, INT_RAW, ICR_WR, ICR_SET, ICR_DATA, PEND_CLR, PEND_CLR_DATA,
               INT_ACK, INT_DONE,
        output INT_REQ, INT_VEC, ICR_Q, PEND_Q, BUSY, ACK_ERR
    );
endinterface

// File: rtl/lvda_int_sched_prienc.sv
// Fixed-priority encoder: reports the lowest set index and whether any bit is set.
module lvda_int_prienc
    import lvda_int_pkg::*;
#(
    parameter int NUM_INT = NUM_INT_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_INT-1:0] bits,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [31:0] bits_ext;

    assign bits_ext = 32'(bits);
    assign idx      = IDX_W'(lowest_set(bits_ext, NUM_INT));
    assign valid    = |bits;

endmodule

// File: rtl/lvda_int_sched.sv
// LVDA interrupt scheduler: latches source edges, masks them with the inhibit
// register and runs one request/acknowledge/end-of-service handshake at a time.
module lvda_int_sched
    import lvda_int_pkg::*;
#(
    parameter int NUM_INT = NUM_INT_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    lvda_int_sched_if.slave bus
);

    sched_state_t            state;
    sched_state_t            state_next;
    logic [NUM_INT-1:0]      prev_raw;
    logic [NUM_INT-1:0]      pend;
    logic [NUM_INT-1:0]      icr;
    logic [NUM_INT-1:0]      rise;
    logic [NUM_INT-1:0]      clr;
    logic [NUM_INT-1:0]      ack_mask;
    logic [NUM_INT-1:0]      active;
    logic [IDX_W-1:0]        vec;
    logic [IDX_W-1:0]        vec_next;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_valid;
    logic                    req;
    logic                    req_next;
    logic                    ack_err;
    logic                    ack_err_next;
    logic                    ack_take;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [HOLD_CNT_W-1:0]   hold_cnt_next;

    assign rise     = bus.INT_RAW & ~prev_raw;
    assign active   = pend & ~icr;
    assign ack_mask = ack_take ? (NUM_INT'(1) << vec) : '0;
    assign clr      = (bus.PEND_CLR ? bus.PEND_CLR_DATA : '0) | ack_mask;

    lvda_int_prienc #(
        .NUM_INT (NUM_INT),
        .IDX_W   (IDX_W)
    ) u_prienc (
        .bits  (active),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Edge history, pending and inhibit registers; a new edge beats any clear.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            prev_raw <= '0;
            pend     <= '0;
            icr      <= '1;
        end else if (bus.V1) begin
            prev_raw <= bus.INT_RAW;
            pend     <= (pend & ~clr) | rise;
            if (bus.ICR_WR) begin
                icr <= bus.ICR_SET ? (icr | bus.ICR_DATA) : (icr & ~bus.ICR_DATA);
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state    <= IDLE;
            req      <= 1'b0;
            vec      <= '0;
            ack_err  <= 1'b0;
            hold_cnt <= '0;
        end else if (bus.V1) begin
            state    <= state_next;
            req      <= req_next;
            vec      <= vec_next;
            ack_err  <= ack_err_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // An acknowledge outranks withdrawal; only REQ accepts it, elsewhere it is an error.
    always_comb begin
        state_next    = state;
        req_next      = req;
        vec_next      = vec;
        hold_cnt_next = hold_cnt;
        ack_err_next  = 1'b0;
        ack_take      = 1'b0;
        unique case (state)
            IDLE: begin
                ack_err_next = bus.INT_ACK;
                if (win_valid) begin
                    state_next = REQ;
                    vec_next   = win_idx;
                    req_next   = 1'b1;
                end
            end
            REQ: begin
                if (bus.INT_ACK) begin
                    state_next = SERVICE;
                    req_next   = 1'b0;
                    ack_take   = 1'b1;
                end else if (!pend[vec] || icr[vec]) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            SERVICE: begin
                ack_err_next = bus.INT_ACK;
                if (bus.INT_DONE) begin
                    if (HOLDOFF == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = HOLD;
                        hold_cnt_next = HOLD_CNT_W'(HOLDOFF - 1);
                    end
                end
            end
            HOLD: begin
                ack_err_next = bus.INT_ACK;
                if (hold_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    assign bus.INT_REQ = req;
    assign bus.INT_VEC = vec;
    assign bus.ICR_Q   = icr;
    assign bus.PEND_Q  = pend;
    assign bus.BUSY    = (state != IDLE);
    assign bus.ACK_ERR = ack_err;

endmodule

// File: tb/tb_lvda_int_sched.sv
// Self-checking bench for lvda_int_sched: a request monitor pops expected
// vectors from a scoreboard queue; directed checks cover register state.
module tb_lvda_int_sched;

    localparam int NUM_INT = 12;
    localparam int IDX_W   = 4;

    logic clk;
    logic rst_n;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];
    int sb_exp;
    logic prev_req = 1'b0;

    lvda_int_sched_if #(.NUM_INT(NUM_INT), .IDX_W(IDX_W)) bus ();

    lvda_int_sched #(.NUM_INT(NUM_INT), .IDX_W(IDX_W), .HOLDOFF(3)) dut (
        .SIM_CLK (clk),
        .SIM_RST (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_INT-1:0] raw);
        bus.INT_RAW = raw;
    endtask

    task automatic waitReq(input int limit, input string tag);
        for (int i = 0; i < limit && !bus.INT_REQ; i++) tick();
        checkOutput(tag, 32'(bus.INT_REQ), 32'd1);
    endtask

    task automatic waitIdle(input int limit, input string tag);
        for (int i = 0; i < limit && bus.BUSY; i++) tick();
        checkOutput(tag, 32'(bus.BUSY), 32'd0);
    endtask

    task automatic serviceReq(input string tag);
        bus.INT_ACK = 1'b1;
        tick();
        bus.INT_ACK = 1'b0;
        checkOutput({tag, "_req_drop"}, 32'(bus.INT_REQ), 32'd0);
        bus.INT_DONE = 1'b1;
        tick();
        bus.INT_DONE = 1'b0;
        waitIdle(10, {tag, "_idle"});
    endtask

    // Every new request must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.INT_REQ && !prev_req) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_req", 32'(bus.INT_REQ), 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                checkOutput("sb_vec", 32'(bus.INT_VEC), 32'(sb_exp));
            end
        end
        prev_req = bus.INT_REQ;
    end

    initial begin
        rst_n             = 1'b0;
        bus.V1            = 1'b1;
        bus.INT_RAW       = '0;
        bus.ICR_WR        = 1'b0;
        bus.ICR_SET       = 1'b0;
        bus.ICR_DATA      = '0;
        bus.PEND_CLR      = 1'b0;
        bus.PEND_CLR_DATA = '0;
        bus.INT_ACK       = 1'b0;
        bus.INT_DONE      = 1'b0;
        repeat (3) tick();
        checkOutput("rst_icr",  32'(bus.ICR_Q),   32'hFFF);
        checkOutput("rst_pend", 32'(bus.PEND_Q),  32'h000);
        checkOutput("rst_req",  32'(bus.INT_REQ), 32'd0);
        checkOutput("rst_vec",  32'(bus.INT_VEC), 32'd0);
        checkOutput("rst_busy", 32'(bus.BUSY),    32'd0);
        checkOutput("rst_ackerr", 32'(bus.ACK_ERR), 32'd0);
        rst_n = 1'b1;
        tick();

        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b0; bus.ICR_DATA = 12'hFFF;
        tick();
        bus.ICR_WR = 1'b0;
        checkOutput("icr_clear_all", 32'(bus.ICR_Q), 32'h000);

        // Single source: latency, acknowledge and holdoff.
        exp_q.push_back(5);
        applyStimulus(12'h020);
        tick();
        checkOutput("t1_pend", 32'(bus.PEND_Q), 32'h020);
        checkOutput("t1_req_early", 32'(bus.INT_REQ), 32'd0);
        applyStimulus(12'h000);
        tick();
        checkOutput("t1_req", 32'(bus.INT_REQ), 32'd1);
        checkOutput("t1_vec", 32'(bus.INT_VEC), 32'd5);
        bus.INT_ACK = 1'b1;
        tick();
        bus.INT_ACK = 1'b0;
        checkOutput("t1_ack_req", 32'(bus.INT_REQ), 32'd0);
        checkOutput("t1_ack_pend", 32'(bus.PEND_Q), 32'h000);
        checkOutput("t1_svc_busy", 32'(bus.BUSY), 32'd1);
        bus.INT_DONE = 1'b1;
        tick();
        bus.INT_DONE = 1'b0;
        tick();
        tick();
        checkOutput("t1_hold_busy", 32'(bus.BUSY), 32'd1);
        tick();
        checkOutput("t1_hold_done", 32'(bus.BUSY), 32'd0);

        // Two simultaneous edges: lower index first, the other after holdoff.
        exp_q.push_back(2);
        exp_q.push_back(7);
        applyStimulus(12'h084);
        tick();
        checkOutput("t2_pend", 32'(bus.PEND_Q), 32'h084);
        applyStimulus(12'h000);
        tick();
        checkOutput("t2_vec_first", 32'(bus.INT_VEC), 32'd2);
        bus.INT_ACK = 1'b1;
        tick();
        bus.INT_ACK = 1'b0;
        checkOutput("t2_pend_left", 32'(bus.PEND_Q), 32'h080);
        bus.INT_DONE = 1'b1;
        tick();
        bus.INT_DONE = 1'b0;
        repeat (3) tick();
        checkOutput("t2_quiet_holdoff", 32'(bus.INT_REQ), 32'd0);
        waitReq(10, "t2_second_req");
        checkOutput("t2_vec_second", 32'(bus.INT_VEC), 32'd7);
        serviceReq("t2");

        // Inhibited source stays pending until unmasked.
        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b1; bus.ICR_DATA = 12'h008;
        tick();
        bus.ICR_WR = 1'b0;
        checkOutput("t3_icr_set", 32'(bus.ICR_Q), 32'h008);
        applyStimulus(12'h008);
        tick();
        applyStimulus(12'h000);
        tick();
        tick();
        checkOutput("t3_pend_masked", 32'(bus.PEND_Q), 32'h008);
        checkOutput("t3_no_req", 32'(bus.INT_REQ), 32'd0);
        exp_q.push_back(3);
        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b0; bus.ICR_DATA = 12'h008;
        tick();
        bus.ICR_WR = 1'b0;
        tick();
        checkOutput("t3_req", 32'(bus.INT_REQ), 32'd1);
        checkOutput("t3_vec", 32'(bus.INT_VEC), 32'd3);
        serviceReq("t3");

        // Masking the presented source withdraws the request.
        exp_q.push_back(4);
        applyStimulus(12'h010);
        tick();
        applyStimulus(12'h000);
        tick();
        checkOutput("t4_req", 32'(bus.INT_REQ), 32'd1);
        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b1; bus.ICR_DATA = 12'h010;
        tick();
        bus.ICR_WR = 1'b0;
        checkOutput("t4_req_still", 32'(bus.INT_REQ), 32'd1);
        tick();
        checkOutput("t4_withdrawn", 32'(bus.INT_REQ), 32'd0);
        checkOutput("t4_pend_kept", 32'(bus.PEND_Q), 32'h010);
        checkOutput("t4_ackerr", 32'(bus.ACK_ERR), 32'd0);
        checkOutput("t4_idle", 32'(bus.BUSY), 32'd0);
        bus.PEND_CLR = 1'b1; bus.PEND_CLR_DATA = 12'h010;
        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b0; bus.ICR_DATA = 12'h010;
        tick();
        bus.PEND_CLR = 1'b0; bus.ICR_WR = 1'b0;
        checkOutput("t4_cleanup_pend", 32'(bus.PEND_Q), 32'h000);

        // New edge beats a same-cycle clear; stray acknowledge flags an error.
        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b1; bus.ICR_DATA = 12'h001;
        tick();
        bus.ICR_WR = 1'b0;
        bus.PEND_CLR = 1'b1; bus.PEND_CLR_DATA = 12'h001;
        applyStimulus(12'h001);
        tick();
        bus.PEND_CLR = 1'b0;
        applyStimulus(12'h000);
        checkOutput("t5_set_wins", 32'(bus.PEND_Q), 32'h001);
        bus.INT_ACK = 1'b1;
        tick();
        bus.INT_ACK = 1'b0;
        checkOutput("t5_ackerr", 32'(bus.ACK_ERR), 32'd1);
        checkOutput("t5_still_idle", 32'(bus.BUSY), 32'd0);
        tick();
        checkOutput("t5_ackerr_pulse", 32'(bus.ACK_ERR), 32'd0);
        bus.PEND_CLR = 1'b1; bus.PEND_CLR_DATA = 12'h001;
        bus.ICR_WR = 1'b1; bus.ICR_SET = 1'b0; bus.ICR_DATA = 12'h001;
        tick();
        bus.PEND_CLR = 1'b0; bus.ICR_WR = 1'b0;
        checkOutput("t5_cleanup_icr", 32'(bus.ICR_Q), 32'h000);

        // Phase enable low freezes everything; the edge is seen once V1 returns.
        bus.V1 = 1'b0;
        applyStimulus(12'h040);
        repeat (5) tick();
        checkOutput("t6_frozen_pend", 32'(bus.PEND_Q), 32'h000);
        checkOutput("t6_frozen_req", 32'(bus.INT_REQ), 32'd0);
        exp_q.push_back(6);
        bus.V1 = 1'b1;
        tick();
        checkOutput("t6_pend", 32'(bus.PEND_Q), 32'h040);
        tick();
        checkOutput("t6_req", 32'(bus.INT_REQ), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_req", 32'(bus.INT_REQ), 32'd0);
        checkOutput("t6_rst_icr", 32'(bus.ICR_Q), 32'hFFF);
        checkOutput("t6_rst_pend", 32'(bus.PEND_Q), 32'h000);
        applyStimulus(12'h000);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
